// File: rtl/pport_arb_pkg.sv
// Shared types and constants for the parallel-port bus arbiter.
package pport_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic REQ_NIOS = 1'b0;
    localparam logic REQ_CNT  = 1'b1;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_SETUP_CYC  = 1;
    localparam int unsigned DEF_STROBE_CYC = 2;
    localparam int unsigned DEF_HOLD_CYC   = 1;
    localparam int unsigned DEF_CNT_W      = 8;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
        if (req == 2'b11) begin
            return ~last_grant;
        end
        return req[1] ? REQ_CNT : REQ_NIOS;
    endfunction

endpackage

// File: rtl/pport_rr_arb2.sv
// Two-way round-robin grant with its last-grant pointer.
module pport_rr_arb2
    import pport_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       update_en,
    output logic       grant_c
);

    logic last_grant;

    assign grant_c = rr_pick(req, last_grant);

    // Pointer starts at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= REQ_CNT;
        end else if (update_en) begin
            last_grant <= grant_c;
        end
    end

endmodule

// File: rtl/pport_bus_arbiter.sv
// Shares the external parallel-port bus between the Nios bridge and the counter
// engine, sequencing each access through setup/strobe/hold phases.
module pport_bus_arbiter
    import pport_arb_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
    parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] pp_dout,
    input  logic [DATA_W-1:0] pp_din,
    output logic              pp_oe,
    output logic              pp_strobe,
    output logic              pp_we,
    output logic              busy
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    state_t             state_q, state_nx;
    logic [CNT_W-1:0]   cnt_q, cnt_nx;
    logic               grant_q, grant_nx;
    logic               we_q, we_nx;
    logic [DATA_W-1:0]  wdata_q, wdata_nx;
    logic [DATA_W-1:0]  rdata_q, rdata_nx;

    logic               grant_c;
    logic               arb_upd_c;
    logic               busy_nx;
    logic               drive_nx;
    logic               ack_nx;
    logic [DATA_W-1:0]  dout_nx;
    logic [DATA_W-1:0]  rdata_out_nx;

    pport_rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       ({req1, req0}),
        .update_en (arb_upd_c),
        .grant_c   (grant_c)
    );

    // Next-state, phase counter and transaction latches.
    always_comb begin
        state_nx  = state_q;
        cnt_nx    = cnt_q;
        grant_nx  = grant_q;
        we_nx     = we_q;
        wdata_nx  = wdata_q;
        rdata_nx  = rdata_q;
        arb_upd_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    arb_upd_c = 1'b1;
                    grant_nx  = grant_c;
                    we_nx     = grant_c ? we1 : we0;
                    wdata_nx  = grant_c ? wdata1 : wdata0;
                    rdata_nx  = '0;
                    cnt_nx    = SETUP_LD;
                    state_nx  = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    cnt_nx   = STROBE_LD;
                    state_nx = STROBE;
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_nx = pp_din;
                    end
                    cnt_nx   = HOLD_LD;
                    state_nx = HOLD;
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, so every bus pin leaves a flop.
    always_comb begin
        busy_nx      = (state_nx != IDLE);
        drive_nx     = busy_nx && we_nx;
        ack_nx       = (state_nx == HOLD) && (cnt_nx == '0);
        dout_nx      = drive_nx ? wdata_nx : '0;
        rdata_out_nx = ack_nx ? rdata_nx : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            grant_q   <= REQ_NIOS;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            busy      <= 1'b0;
            pp_oe     <= 1'b0;
            pp_we     <= 1'b0;
            pp_strobe <= 1'b0;
            pp_dout   <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state_q   <= state_nx;
            cnt_q     <= cnt_nx;
            grant_q   <= grant_nx;
            we_q      <= we_nx;
            wdata_q   <= wdata_nx;
            rdata_q   <= rdata_nx;
            busy      <= busy_nx;
            pp_oe     <= drive_nx;
            pp_we     <= drive_nx;
            pp_strobe <= (state_nx == STROBE);
            pp_dout   <= dout_nx;
            ack0      <= ack_nx && (grant_nx == REQ_NIOS);
            ack1      <= ack_nx && (grant_nx == REQ_CNT);
            rdata0    <= (grant_nx == REQ_NIOS) ? rdata_out_nx : '0;
            rdata1    <= (grant_nx == REQ_CNT) ? rdata_out_nx : '0;
        end
    end

endmodule

// File: tb/tb_pport_bus_arbiter.sv
// Scoreboarded bench for pport_bus_arbiter: default-phase instance plus a
// 3/1/2 phase instance.
module tb_pport_bus_arbiter;

    localparam int unsigned DW = 32;

    typedef struct {
        int              who;
        logic [DW-1:0]   rdata;
        int              due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          req0, we0, req1, we1;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, pp_dout, pp_din;
    logic          ack0, ack1, pp_oe, pp_strobe, pp_we, busy;

    logic          p_req0, p_we0, p_req1, p_we1;
    logic [DW-1:0] p_wdata0, p_wdata1, p_rdata0, p_rdata1, p_pp_dout, p_pp_din;
    logic          p_ack0, p_ack1, p_pp_oe, p_pp_strobe, p_pp_we, p_busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb_q[$];

    pport_bus_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .we0(we0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
        .pp_dout(pp_dout), .pp_din(pp_din), .pp_oe(pp_oe),
        .pp_strobe(pp_strobe), .pp_we(pp_we), .busy(busy)
    );

    pport_bus_arbiter #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) dut_p (
        .clk(clk), .reset_n(reset_n),
        .req0(p_req0), .we0(p_we0), .wdata0(p_wdata0), .rdata0(p_rdata0), .ack0(p_ack0),
        .req1(p_req1), .we1(p_we1), .wdata1(p_wdata1), .rdata1(p_rdata1), .ack1(p_ack1),
        .pp_dout(p_pp_dout), .pp_din(p_pp_din), .pp_oe(p_pp_oe),
        .pp_strobe(p_pp_strobe), .pp_we(p_pp_we), .busy(p_busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the default instance: every ack pops one expectation.
    initial begin
        exp_t e;
        forever begin
            tick();
            if (ack0 || ack1) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_ack", DW'({ack1, ack0}), '0);
                end else begin
                    e = sb_q.pop_front();
                    check_val("ack_who", DW'({ack1, ack0}), (e.who == 0) ? 32'd1 : 32'd2);
                    check_val("ack_cycle", DW'(cyc), DW'(e.due));
                    check_val("rdata0", rdata0, (e.who == 0) ? e.rdata : '0);
                    check_val("rdata1", rdata1, (e.who == 1) ? e.rdata : '0);
                end
            end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
                e = sb_q.pop_front();
                check_val("ack_missing", DW'(cyc), DW'(e.due));
            end
        end
    end

    // One transaction on the default instance with per-cycle bus checks.
    task automatic run_txn(input int who, input logic we, input logic [DW-1:0] wd,
                           input logic [DW-1:0] din, input bit early_drop);
        exp_t          e;
        logic [DW-1:0] dout_exp;
        dout_exp = we ? wd : '0;
        pp_din   = ~din;
        if (who == 0) begin
            req0 = 1'b1; we0 = we; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; wdata1 = wd;
        end
        e.who   = who;
        e.rdata = we ? '0 : din;
        e.due   = cyc + 4;
        sb_q.push_back(e);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_val($sformatf("oe_c%0d", i), DW'(pp_oe), DW'(we));
            check_val($sformatf("we_c%0d", i), DW'(pp_we), DW'(we));
            check_val($sformatf("dout_c%0d", i), pp_dout, dout_exp);
            check_val($sformatf("strobe_c%0d", i), DW'(pp_strobe), DW'(i == 2 || i == 3));
            check_val($sformatf("busy_c%0d", i), DW'(busy), 32'd1);
            pp_din = (i == 3) ? din : ~din;
            if (early_drop && i == 1) begin
                req0 = 1'b0; req1 = 1'b0; wdata0 = ~wd; wdata1 = ~wd;
            end
            if (i == 4) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        tick();
        check_val("turnaround_oe", DW'(pp_oe), '0);
        check_val("idle_busy", DW'(busy), '0);
        check_val("idle_strobe", DW'(pp_strobe), '0);
    endtask

    // Both requesters held for four back-to-back writes.
    task automatic run_contention();
        exp_t e;
        int   t;
        int   p;
        int   k;
        req0 = 1'b1; we0 = 1'b1; wdata0 = 32'hAAAA_0000;
        req1 = 1'b1; we1 = 1'b1; wdata1 = 32'h5555_1111;
        t = cyc;
        for (int n = 0; n < 4; n++) begin
            e.who = n % 2; e.rdata = '0; e.due = t + 4 + 5 * n;
            sb_q.push_back(e);
        end
        for (int c = 1; c <= 20; c++) begin
            p = (c - 1) % 5;
            k = (c - 1) / 5;
            tick();
            check_val($sformatf("cont_oe_c%0d", c), DW'(pp_oe), DW'(p < 4));
            check_val($sformatf("cont_dout_c%0d", c), pp_dout,
                      (p < 4) ? ((k % 2 == 0) ? 32'hAAAA_0000 : 32'h5555_1111) : '0);
            check_val($sformatf("cont_strobe_c%0d", c), DW'(pp_strobe), DW'(p == 1 || p == 2));
            if (c == 19) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
    endtask

    // Reset during STROBE of a requester-0 write, then a fresh grant after release.
    task automatic reset_mid(input bit both);
        exp_t e;
        req0 = 1'b1; we0 = 1'b1; wdata0 = 32'hCAFE_F00D;
        tick();
        tick();
        check_val("pre_rst_strobe", DW'(pp_strobe), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_oe", DW'(pp_oe), '0);
        check_val("rst_strobe", DW'(pp_strobe), '0);
        check_val("rst_ack0", DW'(ack0), '0);
        check_val("rst_busy", DW'(busy), '0);
        check_val("rst_dout", pp_dout, '0);
        req0 = both; we0 = 1'b1; wdata0 = 32'h0000_0A0A;
        req1 = 1'b1; we1 = 1'b1; wdata1 = 32'h0000_0B0B;
        tick();
        reset_n = 1'b1;
        e.who   = both ? 0 : 1;
        e.rdata = '0;
        e.due   = cyc + 4;
        sb_q.push_back(e);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_val($sformatf("post_rst_dout_c%0d", i), pp_dout,
                      both ? 32'h0000_0A0A : 32'h0000_0B0B);
            if (i == 4) begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        tick();
        check_val("post_rst_idle", DW'(busy), '0);
    endtask

    // Read on the 3/1/2 instance: single strobe cycle, ack six cycles after the request.
    task automatic run_param_read(input logic [DW-1:0] din);
        p_pp_din = ~din;
        p_req0 = 1'b1; p_we0 = 1'b0; p_wdata0 = 32'hFFFF_FFFF;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_val($sformatf("p_strobe_c%0d", i), DW'(p_pp_strobe), DW'(i == 4));
            check_val($sformatf("p_ack0_c%0d", i), DW'(p_ack0), DW'(i == 6));
            check_val($sformatf("p_rdata0_c%0d", i), p_rdata0, (i == 6) ? din : '0);
            check_val($sformatf("p_oe_c%0d", i), DW'(p_pp_oe), '0);
            check_val($sformatf("p_busy_c%0d", i), DW'(p_busy), 32'd1);
            p_pp_din = (i == 4) ? din : ~din;
            if (i == 6) p_req0 = 1'b0;
        end
        tick();
        check_val("p_idle_busy", DW'(p_busy), '0);
        check_val("p_idle_ack", DW'(p_ack0), '0);
    endtask

    initial begin
        reset_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; wdata1 = '0;
        pp_din = '0;
        p_req0 = 1'b0; p_we0 = 1'b0; p_wdata0 = '0;
        p_req1 = 1'b0; p_we1 = 1'b0; p_wdata1 = '0;
        p_pp_din = '0;
        tick();
        tick();
        check_val("reset_oe", DW'(pp_oe), '0);
        check_val("reset_strobe", DW'(pp_strobe), '0);
        check_val("reset_busy", DW'(busy), '0);
        check_val("reset_acks", DW'({ack1, ack0}), '0);
        check_val("reset_dout", pp_dout, '0);
        check_val("reset_rdata0", rdata0, '0);
        reset_n = 1'b1;
        tick();

        run_txn(0, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0);
        run_txn(1, 1'b0, 32'h0BAD_0BAD, 32'h1234_5678, 1'b0);
        run_contention();
        tick();
        run_txn(0, 1'b1, 32'h600D_F00D, 32'h0, 1'b1);
        reset_mid(1'b1);
        reset_mid(1'b0);
        run_param_read(32'h8765_4321);

        tick();
        tick();
        check_val("sb_empty", DW'(sb_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
